// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-master memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_i;
    logic [ADDR_W-1:0] addr_i;
    logic              ack_i;
    logic [DATA_W-1:0] rdata_i;
    logic              req_d;
    logic              rw_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              ack_d;
    logic [DATA_W-1:0] rdata_d;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req_i, addr_i, req_d, rw_d, addr_d, wdata_d, mem_rdata,
        output ack_i, rdata_i, ack_d, rdata_d,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_i, addr_i, req_d, rw_d, addr_d, wdata_d, mem_rdata,
        input  ack_i, rdata_i, ack_d, rdata_d,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between
// instruction fetch and data accesses; all outputs registered.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              last_d, last_d_n;
    logic              win_d, win_d_n;
    logic              grant_d;
    logic              en_n, we_n, busy_n;
    logic              ack_i_n, ack_d_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [DATA_W-1:0] rdata_i_n, rdata_d_n;

    // On a tie, data wins only if fetch went last
    assign grant_d = bus.req_d && (!bus.req_i || !last_d);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_d_n  = last_d;
        win_d_n   = win_d;
        en_n      = bus.mem_en;
        we_n      = bus.mem_we;
        addr_n    = bus.mem_addr;
        wdata_n   = bus.mem_wdata;
        busy_n    = bus.busy;
        ack_i_n   = 1'b0;
        ack_d_n   = 1'b0;
        rdata_i_n = bus.rdata_i;
        rdata_d_n = bus.rdata_d;
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (bus.req_i || bus.req_d) begin
                    state_n  = ACCESS;
                    win_d_n  = grant_d;
                    last_d_n = grant_d;
                    en_n     = 1'b1;
                    busy_n   = 1'b1;
                    cnt_n    = CW'(MEM_LAT - 1);
                    if (grant_d) begin
                        we_n    = bus.rw_d;
                        addr_n  = bus.addr_d;
                        wdata_n = bus.wdata_d;
                    end else begin
                        we_n    = 1'b0;
                        addr_n  = bus.addr_i;
                        wdata_n = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_n = RESP;
                    en_n    = 1'b0;
                    we_n    = 1'b0;
                    if (win_d) begin
                        ack_d_n = 1'b1;
                        if (!bus.mem_we) rdata_d_n = bus.mem_rdata;
                    end else begin
                        ack_i_n   = 1'b1;
                        rdata_i_n = bus.mem_rdata;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            last_d        <= 1'b1;
            win_d         <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
            bus.ack_i     <= 1'b0;
            bus.ack_d     <= 1'b0;
            bus.rdata_i   <= '0;
            bus.rdata_d   <= '0;
        end else begin
            cnt           <= cnt_n;
            last_d        <= last_d_n;
            win_d         <= win_d_n;
            bus.mem_en    <= en_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_wdata <= wdata_n;
            bus.busy      <= busy_n;
            bus.ack_i     <= ack_i_n;
            bus.ack_d     <= ack_d_n;
            bus.rdata_i   <= rdata_i_n;
            bus.rdata_d   <= rdata_d_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks,
// a negedge monitor pops and compares them.
module tb_mem_arbiter;
    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk)
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;

    typedef struct {
        bit          is_d;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   en_run = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(bit is_d, logic [15:0] rd);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.ack_i || bus.ack_d) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {bus.ack_i, bus.ack_d}, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_both", 32'(bus.ack_i & bus.ack_d), 0);
                chk("ack_who", 32'(bus.ack_d), 32'(e.is_d));
                chk("ack_rdata", e.is_d ? bus.rdata_d : bus.rdata_i, e.rdata);
            end
        end
        if (rst) begin
            en_run = 0;
        end else if (bus.mem_en) begin
            en_run++;
        end else if (en_run > 0) begin
            chk("mem_en_len", en_run, 2);
            en_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(bit is_d);
        bit got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (is_d ? bus.ack_d : bus.ack_i) begin
                got = 1;
                if (is_d) bus.req_d = 1'b0;
                else      bus.req_i = 1'b0;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    logic [15:0] exp_rd_d;
    int          t4 [4];
    int          n4;

    initial begin
        mem[16'h0010] = 16'hA5A5;
        mem[16'h0020] = 16'h2020;
        mem[16'h0030] = 16'h3333;
        mem[16'h0040] = 16'h4444;
        mem[16'h0050] = 16'h5050;
        mem[16'h0060] = 16'h6060;
        mem[16'h0070] = 16'h7070;
        mem[16'h0200] = 16'h0000;
        rst         = 1'b1;
        bus.req_i   = 1'b1;
        bus.addr_i  = 16'h0030;
        bus.req_d   = 1'b1;
        bus.rw_d    = 1'b0;
        bus.addr_d  = 16'h0040;
        bus.wdata_d = 16'h0000;
        exp_rd_d    = 16'h0000;

        // 1: reset with both requests high, then first tie -> fetch
        tick();
        tick();
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_acks", {bus.ack_i, bus.ack_d}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rdata_i", bus.rdata_i, 0);
        push(0, 16'h3333);
        push(1, 16'h4444);
        exp_rd_d = 16'h4444;
        rst = 1'b0;
        tick();
        chk("t1_first_grant", bus.mem_addr, 16'h0030);
        wait_ack(0);
        wait_ack(1);
        tick();

        // 2: fetch read
        bus.addr_i = 16'h0010;
        bus.req_i  = 1'b1;
        push(0, 16'hA5A5);
        tick();
        chk("t2_en", 32'(bus.mem_en), 1);
        chk("t2_addr", bus.mem_addr, 16'h0010);
        chk("t2_we", 32'(bus.mem_we), 0);
        wait_ack(0);
        chk("t2_ack_d", 32'(bus.ack_d), 0);
        tick();

        // 3: data write
        bus.rw_d    = 1'b1;
        bus.addr_d  = 16'h0200;
        bus.wdata_d = 16'h1234;
        bus.req_d   = 1'b1;
        push(1, exp_rd_d);
        tick();
        chk("t3_we", 32'(bus.mem_we), 1);
        chk("t3_wdata", bus.mem_wdata, 16'h1234);
        wait_ack(1);
        tick();
        chk("t3_mem", mem[16'h0200], 16'h1234);

        // 4: continuous tie -> I, D, I, D spaced MEM_LAT+2 apart
        bus.rw_d   = 1'b0;
        bus.addr_i = 16'h0050;
        bus.addr_d = 16'h0060;
        bus.req_i  = 1'b1;
        bus.req_d  = 1'b1;
        push(0, 16'h5050);
        push(1, 16'h6060);
        push(0, 16'h5050);
        push(1, 16'h6060);
        exp_rd_d = 16'h6060;
        n4 = 0;
        for (int c = 0; c < 40 && n4 < 4; c++) begin
            tick();
            if (bus.ack_i || bus.ack_d) begin
                t4[n4] = c;
                n4++;
                if (n4 == 4) begin
                    bus.req_i = 1'b0;
                    bus.req_d = 1'b0;
                end
            end
        end
        chk("t4_ack_count", n4, 4);
        for (int k = 1; k < 4; k++)
            if (k < n4) chk("t4_spacing", t4[k] - t4[k-1], 4);
        tick();

        // 5: reset in second ACCESS cycle of a data read
        bus.addr_d = 16'h0070;
        bus.req_d  = 1'b1;
        tick();
        tick();
        chk("t5_pre_en", 32'(bus.mem_en), 1);
        rst = 1'b1;
        tick();
        chk("t5_en", 32'(bus.mem_en), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_ack_d", 32'(bus.ack_d), 0);
        rst = 1'b0;
        push(1, 16'h7070);
        wait_ack(1);
        tick();

        // 6: req dropped and addr changed after the grant
        bus.addr_i = 16'h0020;
        bus.req_i  = 1'b1;
        push(0, 16'h2020);
        tick();
        tick();
        bus.req_i  = 1'b0;
        bus.addr_i = 16'h0FFF;
        chk("t6_addr_hold", bus.mem_addr, 16'h0020);
        wait_ack(0);
        chk("t6_addr_final", bus.mem_addr, 16'h0020);
        for (int c = 0; c < 6; c++) tick();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port main memory between two requesters: the instruction-fetch path (IR load) and the data path (MDR/stack accesses issued by the CPU controller). Each request is a multi-cycle transaction. The block drives the address, write-enable and write data for a fixed number of cycles, then captures read data and returns a one-cycle acknowledge to the granted requester. Ties are resolved round-robin, so neither requester can starve the other.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MEM_LAT, 2, cycles mem_en is held per access (must be >= 1); read data is valid on the last of these cycles

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
req_i  in  1  fetch request; held high until ack_i
addr_i  in  ADDR_W  fetch address; stable while req_i high
ack_i  out  1  one-cycle pulse when the fetch completes
rdata_i  out  DATA_W  fetch read data; valid while ack_i high, held afterwards
req_d  in  1  data request; held high until ack_d
rw_d  in  1  1 = write, 0 = read
addr_d  in  ADDR_W  data address
wdata_d  in  DATA_W  data write value
ack_d  out  1  one-cycle pulse when the data access completes
rdata_d  out  DATA_W  data read value; valid while ack_d high, held afterwards
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever the state is not IDLE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, last_grant=D (so the first tie grants fetch), cnt=0, all outputs 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Sample req_i and req_d.
  - Neither high: stay in IDLE.
  - One high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant at edge E: latch the winner's address, write data and rw into internal registers (fetch is always a read). Set mem_en=1, mem_addr, mem_wdata, mem_we=rw, busy=1, cnt=MEM_LAT-1, last_grant=winner. Go to ACCESS.
- ACCESS:
  - mem_en, mem_we, mem_addr and mem_wdata are held constant.
  - cnt decrements each edge.
  - At the edge where cnt==0 (edge E+MEM_LAT):
    - Drop mem_en and mem_we.
    - For a read, capture mem_rdata into rdata_i or rdata_d (winner only).
    - Pulse the winner's ack.
    - Go to RESP.
  - Net effect: mem_en is high for exactly MEM_LAT cycles, and ack is high in the cycle after edge E+MEM_LAT.
- RESP:
  - Requests are ignored.
  - Next edge: ack returns to 0, busy to 0, state to IDLE.
  - Requesters must drop req during the ack cycle; a req still high when IDLE samples is a new transaction.
- Writes leave rdata_i and rdata_d unchanged.
- The losing requester's ack and rdata are never touched.
- A req dropped during ACCESS does not abort the transaction; it completes and ack still pulses once.
- Changes to addr or wdata after the grant have no effect (values are latched).
- Throughput: one transaction per MEM_LAT+2 cycles; with continuous ties the grants alternate I, D, I, D.
- rst during ACCESS or RESP: at the next edge everything returns to reset values, no ack is issued, mem_en drops, and the in-flight transaction is lost.

Test Plan:
1. Reset: hold rst 2 cycles with both reqs high -> all outputs 0, busy=0; after release, grant goes to fetch.
2. Fetch read, MEM_LAT=2: req_i=1, addr_i=0x0010, memory model returns 0xA5A5 -> mem_en high for exactly 2 cycles with mem_addr=0x0010 and mem_we=0; ack_i high for 1 cycle after edge E+2; rdata_i=0xA5A5; ack_d stays 0.
3. Data write: req_d=1, rw_d=1, addr_d=0x0200, wdata_d=0x1234 -> mem_we=1 for 2 cycles; ack_d pulses once; model location 0x0200 reads 0x1234; rdata_d unchanged.
4. Simultaneous requests held continuously for 4 transactions -> grant order I, D, I, D; ack pulses spaced MEM_LAT+2=4 cycles apart.
5. rst asserted in the second ACCESS cycle of a data read -> next edge mem_en=0, busy=0, no ack_d; a following req_d completes normally.
6. req_i dropped and addr_i changed to 0x0FFF one cycle after grant at 0x0020 -> mem_addr stays 0x0020 and ack_i still pulses exactly once.
